// File: rtl/mdu_iter_if.sv
// mdu_iter_if -- request/result handshake between the pipeline and the
// iterative multiply/divide unit.
//   master : pipeline side; drives req_vld, mdu_op, mdu_src1, mdu_src2,
//            flush, res_rdy; observes req_rdy, res_vld, mdu_res
//   slave  : MDU side; drives req_rdy, res_vld, mdu_res
// Datapath width follows `CPU_WIDTH (defaults to 32).

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

interface mdu_iter_if;
   logic                  req_vld;
   logic                  req_rdy;
   logic [2:0]            mdu_op;
   logic [`CPU_WIDTH-1:0] mdu_src1;
   logic [`CPU_WIDTH-1:0] mdu_src2;
   logic                  flush;
   logic                  res_vld;
   logic                  res_rdy;
   logic [`CPU_WIDTH-1:0] mdu_res;

   modport master (
      output req_vld, mdu_op, mdu_src1, mdu_src2, flush, res_rdy,
      input  req_rdy, res_vld, mdu_res
   );

   modport slave (
      input  req_vld, mdu_op, mdu_src1, mdu_src2, flush, res_rdy,
      output req_rdy, res_vld, mdu_res
   );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter -- iterative RV32M multiply/divide unit.
// Multiply: radix-2 shift-add on operand magnitudes, sign fixup at the end.
// Divide:   restoring, one quotient bit per cycle on magnitudes.
// Divide-by-zero and signed overflow skip the iteration and finish at once.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : mdu_iter_if.slave (request, flush, result handshake)
// Build option: define MDU_DIV_EN to include the divider; without it the
// divide ops (100-111) return 0 after one cycle.

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module mdu_iter (
   input  logic      clk,
   input  logic      rst,
   mdu_iter_if.slave bus
);
   // state | meaning
   // IDLE  | waiting for a request, req_rdy high unless flushing
   // CALC  | one multiply or divide step per cycle, counter runs down
   // DONE  | mdu_res valid, held until res_rdy

   localparam int W  = `CPU_WIDTH;
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   state_t          state_q, state_d;
   logic [2:0]      op_q;
   logic [W-1:0]    acc_hi_q, acc_lo_q, opb_q, res_q;
   logic            neg_q;
   logic [CW-1:0]   cnt_q;

   logic            req_rdy, accept;
   logic            s1_signed, s2_signed, s1_neg, s2_neg;
   logic [W-1:0]    a_mag, b_mag;
   logic            bypass;
   logic [W-1:0]    bypass_res;
   logic [W:0]      mul_sum;
   logic [W-1:0]    step_hi, step_lo, mul_res, calc_res;
   logic [2*W-1:0]  prod, prod_s;
`ifdef MDU_DIV_EN
   logic            neg_rem_q;
   logic [W:0]      div_shift;
   logic            div_ge, div_zero, div_ovf;
   logic [W-1:0]    quo, rem;
`endif

   assign req_rdy     = (state_q == IDLE) && !bus.flush;
   assign accept      = bus.req_vld && req_rdy;
   assign bus.req_rdy = req_rdy;
   assign bus.res_vld = (state_q == DONE);
   assign bus.mdu_res = res_q;

   always_comb begin
      s1_signed = 1'b0;
      s2_signed = 1'b0;
      case (bus.mdu_op)
         3'b001, 3'b100, 3'b110: begin
            s1_signed = 1'b1;
            s2_signed = 1'b1;
         end
         3'b010:  s1_signed = 1'b1;
         default: ;
      endcase
   end

   assign s1_neg = s1_signed && bus.mdu_src1[W-1];
   assign s2_neg = s2_signed && bus.mdu_src2[W-1];
   assign a_mag  = s1_neg ? -bus.mdu_src1 : bus.mdu_src1;
   assign b_mag  = s2_neg ? -bus.mdu_src2 : bus.mdu_src2;

`ifdef MDU_DIV_EN
   always_comb begin
      div_zero   = bus.mdu_op[2] && (bus.mdu_src2 == '0);
      // DIV/REM of the most negative value by -1 overflows the quotient
      div_ovf    = bus.mdu_op[2] && !bus.mdu_op[0] &&
                   (bus.mdu_src1 == {1'b1, {(W-1){1'b0}}}) && (bus.mdu_src2 == '1);
      bypass     = div_zero || div_ovf;
      bypass_res = '0;
      if (div_zero)
         bypass_res = bus.mdu_op[1] ? bus.mdu_src1 : '1;
      else if (div_ovf)
         bypass_res = bus.mdu_op[1] ? '0 : {1'b1, {(W-1){1'b0}}};
   end
`else
   assign bypass     = bus.mdu_op[2];
   assign bypass_res = '0;
`endif

   // acc_hi:acc_lo is the running product (multiplier shifts out of acc_lo)
   // or the partial remainder : dividend/quotient pair for division.
   always_comb begin
      mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], acc_lo_q[W-1:1]};
`ifdef MDU_DIV_EN
      div_shift = {acc_hi_q, acc_lo_q[W-1]};
      div_ge    = div_shift >= {1'b0, opb_q};
      if (op_q[2]) begin
         // remainder after a successful subtract is below opb, so W bits suffice
         step_hi = div_ge ? (div_shift[W-1:0] - opb_q) : div_shift[W-1:0];
         step_lo = {acc_lo_q[W-2:0], div_ge};
      end
`endif
   end

   // final result is formed from the last step's output on the same edge
   always_comb begin
      prod    = {step_hi, step_lo};
      prod_s  = neg_q ? -prod : prod;
      mul_res = (op_q[1:0] == 2'b00) ? prod_s[W-1:0] : prod_s[2*W-1:W];
`ifdef MDU_DIV_EN
      quo      = neg_q ? -step_lo : step_lo;
      rem      = neg_rem_q ? -step_hi : step_hi;
      calc_res = op_q[2] ? (op_q[1] ? rem : quo) : mul_res;
`else
      calc_res = op_q[2] ? '0 : mul_res;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (bus.req_vld) state_d = bypass ? DONE : CALC;
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    if (bus.res_rdy) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q      <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         opb_q     <= '0;
         neg_q     <= 1'b0;
         cnt_q     <= '0;
         res_q     <= '0;
`ifdef MDU_DIV_EN
         neg_rem_q <= 1'b0;
`endif
      end else if (accept) begin
         op_q      <= bus.mdu_op;
         acc_hi_q  <= '0;
         acc_lo_q  <= a_mag;
         opb_q     <= b_mag;
         neg_q     <= s1_neg ^ s2_neg;
         cnt_q     <= CW'(W-1);
`ifdef MDU_DIV_EN
         neg_rem_q <= s1_neg;
`endif
         if (bypass) res_q <= bypass_res;
      end else if ((state_q == CALC) && !bus.flush) begin
         acc_hi_q <= step_hi;
         acc_lo_q <= step_lo;
         if (cnt_q == '0) res_q <= calc_res;
         else             cnt_q <= cnt_q - CW'(1);
      end
   end
endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 Parameter-free; datapath width SHALL be `CPU_WIDTH (32), the same width as the ALU operands.
REQ-002 clk  input  1  single clock; all state SHALL change on the rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-high.
REQ-004 req_vld  input  1  operation request valid.
REQ-005 req_rdy  output  1  unit can accept a request.
REQ-006 mdu_op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 mdu_src1  input  `CPU_WIDTH  rs1 operand (multiplicand / dividend).
REQ-008 mdu_src2  input  `CPU_WIDTH  rs2 operand (multiplier / divisor).
REQ-009 flush  input  1  pipeline flush; aborts any operation in flight.
REQ-010 res_vld  output  1  result valid.
REQ-011 res_rdy  input  1  consumer accepts result.
REQ-012 mdu_res  output  `CPU_WIDTH  result, registered.

Function
REQ-013 FSM states SHALL be IDLE, CALC and DONE.
REQ-014 req_rdy SHALL equal (state==IDLE) && !flush, with no combinational path from req_vld.
REQ-015 Acceptance SHALL occur on an edge where req_vld && req_rdy; mdu_op and both operands SHALL be latched there, and inputs SHALL be ignored afterwards.
REQ-016 Multiply SHALL be radix-2 shift-add on 64-bit magnitudes with sign fixup per op; MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32] for signed×signed, signed×unsigned and unsigned×unsigned respectively.
REQ-017 Divide SHALL be restoring, one quotient bit per cycle on magnitudes; quotient sign = sign1^sign2, remainder sign = sign of dividend (signed ops only).
REQ-018 Normal ops SHALL spend exactly `CPU_WIDTH cycles in CALC; res_vld SHALL rise `CPU_WIDTH+1 edges after the acceptance edge (33 for RV32).
REQ-019 Divisor==0 SHALL bypass CALC (IDLE->DONE); res_vld rises 1 edge after acceptance; DIV/DIVU = all ones, REM/REMU = dividend.
REQ-020 Signed overflow (DIV/REM with src1=0x8000_0000, src2=0xFFFF_FFFF) SHALL bypass CALC; DIV = 0x8000_0000, REM = 0.
REQ-021 In DONE, res_vld=1 and mdu_res SHALL hold stable until res_vld && res_rdy; on that edge the FSM SHALL return to IDLE (req_rdy high next cycle, no back-to-back accept in the same edge).
REQ-022 flush=1 SHALL on the next edge force IDLE, clear res_vld and discard the in-flight result, in any state; flush has priority over res_rdy and req_vld.
REQ-023 mdu_res SHALL retain its last value outside DONE; only res_vld qualifies it.

Reset
REQ-024 On rst: state=IDLE, res_vld=0, mdu_res=0, iteration counter=0, internal accumulators=0; req_rdy=1 once rst deasserts.
REQ-025 rst asserted mid-CALC or in DONE SHALL abort immediately; no result SHALL be delivered for that operation.

Configuration
REQ-026 Macro MDU_DIV_EN: when defined, all eight ops SHALL be implemented as above.
REQ-027 When MDU_DIV_EN is not defined, the divider datapath SHALL be absent; ops 100-111 SHALL bypass to DONE with res_vld 1 edge after acceptance and mdu_res=0; multiply behaviour SHALL be unchanged.

Verification
REQ-028 MUL 7×(-3) (0x7, 0xFFFF_FFFD), res_rdy=1 -> res_vld on edge 33, mdu_res=0xFFFF_FFEB, req_rdy back high next cycle.
REQ-029 MULHU 0xFFFF_FFFF×0xFFFF_FFFF -> 0xFFFF_FFFE; MULH same operands -> 0x0000_0000; MULHSU 0xFFFF_FFFF×0x2 -> 0xFFFF_FFFF.
REQ-030 DIV -7/2 -> 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF; DIVU 100/0 -> 0xFFFF_FFFF after 1 cycle; REMU 100/0 -> 100.
REQ-031 DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000 after 1 cycle; REM same -> 0.
REQ-032 Hold res_rdy=0 for 5 cycles after res_vld -> res_vld and mdu_res stable, req_rdy=0 throughout; release -> IDLE next edge.
REQ-033 flush at cycle 10 of CALC with req_vld held -> IDLE next edge, res_vld never rises, the held request is accepted on the first edge with flush=0; rst pulse mid-CALC -> all outputs at reset values.
